seconds_timebase: RTL and testbench

//   Upstream timebase for the seconds/7-segment counter chain. Divides the board clock into a
//   one-cycle tick at TICK_HZ, plus a 50 % duty blink level for an LED.
//   Two active-low pushbuttons, debounced on-chip, provide run/pause toggle and clear.

---
 rtl/seconds_timebase.sv | 140 ++++++++++++++
 tb/tb_seconds_timebase.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seconds_timebase.sv
// Seconds timebase: divides clk to a one-cycle tick plus a 50% blink level, with debounced run/pause and clear buttons.
// Build option: define AUTO_START_EN to come out of reset running instead of stopped.
module seconds_timebase #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_run_n,
  input  logic btn_clr_n,
  output logic tick,
  output logic half_sec,
  output logic running,
  output logic clear
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam int DCW = $clog2(DEBOUNCE_CYC + 1);

  if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
    $error("seconds_timebase: CLK_HZ/TICK_HZ must be even and at least 4");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_deb
    $error("seconds_timebase: DEBOUNCE_CYC must be at least 1");
  end

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } state_t;

`ifdef AUTO_START_EN
  localparam state_t RST_STATE = RUN;
`else
  localparam state_t RST_STATE = STOPPED;
`endif

  // Index 0 is the run button, index 1 the clear button.
  logic [1:0]     btn_n;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q, deb_d;
  logic [1:0]     armed_q, armed_d;
  logic [1:0]     press_q, press_d;
  logic [1:0]     fill_q;
  logic [DCW-1:0] dcnt_q [2];
  logic [DCW-1:0] dcnt_d [2];

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tick_q, tick_d;
  logic           half_q, half_d;
  logic           clear_q, clear_d;

  assign btn_n = {btn_clr_n, btn_run_n};

  // A press only counts once the button has been seen released after reset, so a button
  // held through reset release cannot fire; fill_q marks when sync2_q carries real samples.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b]   = deb_q[b];
      dcnt_d[b]  = '0;
      press_d[b] = 1'b0;
      armed_d[b] = armed_q[b] | (fill_q[1] & sync2_q[b]);
      if (sync2_q[b] != deb_q[b]) begin
        if (dcnt_q[b] == DCW'(DEBOUNCE_CYC - 1)) begin
          deb_d[b]   = sync2_q[b];
          press_d[b] = ~sync2_q[b] & armed_q[b];
        end else begin
          dcnt_d[b] = dcnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (press_q[0]) state_d = RUN;
      RUN:     if (press_q[0]) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase

    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    if (state_q == RUN) begin
      if (cnt_q == CW'(DIV - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Clear overrides a coincident wrap, so no tick escapes alongside it.
    if (press_q[1]) begin
      cnt_d   = '0;
      tick_d  = 1'b0;
      clear_d = 1'b1;
    end
    half_d = (cnt_d >= CW'(DIV / 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      armed_q <= 2'b00;
      press_q <= 2'b00;
      fill_q  <= 2'b00;
      for (int b = 0; b < 2; b++) dcnt_q[b] <= '0;
      state_q <= RST_STATE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      half_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      armed_q <= armed_d;
      press_q <= press_d;
      fill_q  <= {fill_q[0], 1'b1};
      for (int b = 0; b < 2; b++) dcnt_q[b] <= dcnt_d[b];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      half_q  <= half_d;
      clear_q <= clear_d;
    end
  end

  assign tick     = tick_q;
  assign half_sec = half_q;
  assign running  = (state_q == RUN);
  assign clear    = clear_q;

endmodule

// File: tb/tb_seconds_timebase.sv
// Bench for seconds_timebase: directed and random button stimulus checked cycle by cycle against a reference model.
module tb_seconds_timebase;
  localparam int CLK_HZ = 20;
  localparam int TICK_HZ = 1;
  localparam int DEB = 4;
  localparam int DIV = CLK_HZ / TICK_HZ;
`ifdef AUTO_START_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, btn_run_n, btn_clr_n;
  logic tick, half_sec, running, clear;
  int tests = 0;
  int fails = 0;

  seconds_timebase #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run_n(btn_run_n), .btn_clr_n(btn_clr_n),
    .tick(tick), .half_sec(half_sec), .running(running), .clear(clear)
  );

  always #5 clk = ~clk;

  // Reference model: raw button samples per edge since reset, debounced levels, pending events.
  bit hist [2][0:4095];
  int ek;
  bit deb_m [2];
  bit ev_m [2];
  bit running_m, tick_m, half_m, clear_m;
  int pos_m;

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ek = 0;
    deb_m = '{1'b1, 1'b1};
    ev_m = '{1'b0, 1'b0};
    running_m = AUTO;
    pos_m = 0;
    tick_m = 1'b0;
    half_m = 1'b0;
    clear_m = 1'b0;
  endtask

  function automatic bit samp(input int b, input int j);
    if (j < 1) return 1'b1;
    return hist[b][j];
  endfunction

  function automatic bit seen_high(input int b, input int upto);
    for (int j = 1; j <= upto; j++) if (hist[b][j]) return 1'b1;
    return 1'b0;
  endfunction

  // A button sample taken at edge j reaches the debouncer at edge j+2; the level flips once the
  // last DEB delivered samples all disagree with it, and a press acts on the edge after that.
  task automatic model_edge();
    bit run_e, clr_e, flip;
    ek++;
    hist[0][ek] = btn_run_n;
    hist[1][ek] = btn_clr_n;
    run_e = ev_m[0];
    clr_e = ev_m[1];
    tick_m = 1'b0;
    clear_m = 1'b0;
    if (running_m) begin
      pos_m = pos_m + 1;
      if (pos_m == DIV) begin
        pos_m = 0;
        tick_m = 1'b1;
      end
    end
    if (clr_e) begin
      pos_m = 0;
      tick_m = 1'b0;
      clear_m = 1'b1;
    end
    if (run_e) running_m = !running_m;
    half_m = (pos_m >= DIV / 2);
    for (int b = 0; b < 2; b++) begin
      ev_m[b] = 1'b0;
      flip = 1'b1;
      for (int j = ek - 1 - DEB; j <= ek - 2; j++) if (samp(b, j) == deb_m[b]) flip = 1'b0;
      if (flip) begin
        deb_m[b] = !deb_m[b];
        if (!deb_m[b] && seen_high(b, ek - 2)) ev_m[b] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk1("tick", tick, tick_m);
    chk1("half_sec", half_sec, half_m);
    chk1("running", running, running_m);
    chk1("clear", clear, clear_m);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic wait_pos(input int v);
    int n = 0;
    while (pos_m != v && n < 200) begin
      cyc(1);
      n++;
    end
    tests++;
    assert (n < 200) else begin
      fails++;
      $error("FAIL wait_pos: timed out waiting for count %0d", v);
    end
  endtask

  initial begin
    int n, cnt_a, cnt_b, toggles, at, rise_i, tick_i, seg_r, seg_c;
    logic prev, last;

    rst_n = 1'b0;
    btn_run_n = 1'b1;
    btn_clr_n = 1'b1;
    model_reset();
    repeat (2) begin @(posedge clk); #1; check_outputs(); end
    chk1("rst_running", running, AUTO);
    rst_n = 1'b1;

    // Idle: no ticks when stopped.
    cnt_a = 0;
    for (int i = 0; i < 100; i++) begin cyc(1); cnt_a += int'(tick); end
    chkn("idle_ticks", cnt_a, AUTO ? 5 : 0);

    // Run press held 10 cycles: toggle on cycle 7, first tick DIV cycles later.
    prev = running;
    btn_run_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i == 6) chk1("run_lat_6", running, prev);
      if (i == 7) chk1("run_lat_7", running, !prev);
    end
    btn_run_n = 1'b1;
    n = 3;
    while (!tick && n < 60) begin cyc(1); n++; end
    chkn("first_tick", n, DIV);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < DIV; i++) begin cyc(1); cnt_a += int'(tick); cnt_b += int'(half_sec); end
    chkn("period_ticks", cnt_a, 1);
    chkn("half_high", cnt_b, DIV / 2);

    // Bounce: short lows never accepted, then one toggle after stable low.
    toggles = 0;
    last = running;
    for (int s = 0; s < 4; s++) begin
      btn_run_n = s[0];
      n = int'($urandom_range(1, DEB - 1));
      for (int k = 0; k < n; k++) begin
        cyc(1);
        if (running !== last) toggles++;
        last = running;
      end
    end
    chkn("bounce_none", toggles, 0);
    btn_run_n = 1'b0;
    at = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (running !== last) begin toggles++; if (at == 0) at = i; end
      last = running;
    end
    btn_run_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (running !== last) toggles++;
      last = running;
    end
    chkn("bounce_delay", at, 7);
    chkn("bounce_once", toggles, 1);

    // Restart, then pause with the count frozen at 13.
    btn_run_n = 1'b0;
    cyc(10);
    btn_run_n = 1'b1;
    cyc(5);
    chk1("restarted", running, 1'b1);
    wait_pos(6);
    btn_run_n = 1'b0;
    cyc(10);
    btn_run_n = 1'b1;
    chk1("paused", running, 1'b0);
    chk1("pause_half", half_sec, 1'b1);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 50; i++) begin cyc(1); cnt_a += int'(tick); cnt_b += int'(half_sec); end
    chkn("pause_ticks", cnt_a, 0);
    chkn("pause_half_hold", cnt_b, 50);
    btn_run_n = 1'b0;
    rise_i = 0;
    tick_i = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (i == 10) btn_run_n = 1'b1;
      if (running && rise_i == 0) rise_i = i;
      if (tick && tick_i == 0) tick_i = i;
    end
    chkn("resume_rise", rise_i, 7);
    chkn("resume_tick", tick_i - rise_i, 7);

    // Clear event landing on the wrap cycle.
    wait_pos(13);
    btn_clr_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i == 7) begin
        chk1("clr_pulse", clear, 1'b1);
        chk1("clr_no_tick", tick, 1'b0);
        chk1("clr_half", half_sec, 1'b0);
        chk1("clr_running", running, 1'b1);
      end
      if (i == 8) chk1("clr_one_cycle", clear, 1'b0);
    end
    btn_clr_n = 1'b1;
    n = 3;
    while (!tick && n < 60) begin cyc(1); n++; end
    chkn("clr_next_tick", n, DIV);

    // Both buttons together: one clear and one toggle.
    prev = running;
    btn_run_n = 1'b0;
    btn_clr_n = 1'b0;
    cnt_a = 0;
    for (int i = 1; i <= 25; i++) begin
      cyc(1);
      if (i == 10) begin btn_run_n = 1'b1; btn_clr_n = 1'b1; end
      cnt_a += int'(clear);
      if (i == 7) begin
        chk1("both_clear", clear, 1'b1);
        chk1("both_toggle", running, !prev);
      end
    end
    chkn("both_clear_count", cnt_a, 1);
    chk1("both_final", running, !prev);

    // Random button activity with bounces and genuine presses.
    seg_r = int'($urandom_range(1, 12));
    seg_c = int'($urandom_range(1, 12));
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      seg_r--;
      seg_c--;
      if (seg_r == 0) begin btn_run_n = ~btn_run_n; seg_r = int'($urandom_range(1, 12)); end
      if (seg_c == 0) begin btn_clr_n = ~btn_clr_n; seg_c = int'($urandom_range(1, 12)); end
    end
    btn_run_n = 1'b1;
    btn_clr_n = 1'b1;
    cyc(12);

    // Asynchronous reset in the second half of a running period.
    if (!running_m) begin
      btn_run_n = 1'b0;
      cyc(10);
      btn_run_n = 1'b1;
      cyc(8);
    end
    chk1("pre_rst_running", running, 1'b1);
    wait_pos(15);
    rst_n = 1'b0;
    #1;
    chk1("arst_tick", tick, 1'b0);
    chk1("arst_half", half_sec, 1'b0);
    chk1("arst_clear", clear, 1'b0);
    chk1("arst_running", running, AUTO);
    model_reset();
    btn_run_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; check_outputs(); end
    rst_n = 1'b1;

    // Run button held through reset release must not fire.
    cyc(20);
    chk1("held_no_event", running, AUTO);
    btn_run_n = 1'b1;
    cyc(10);
    btn_run_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i == 7) chk1("repress_toggle", running, !AUTO);
    end
    btn_run_n = 1'b1;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
